// File: rtl/alu_share_arb.sv
// Two-channel round-robin arbiter sharing one WIDTH-bit ALU (AND/OR/SUB/ADD).
// Optional per-channel grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_code,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_code,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  localparam int unsigned CODE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                grant0;
  logic                grant1;
  logic [CODE_W-1:0]   op_code;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                op_id;
  logic [WIDTH-1:0]    alu_y;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant; rst_n gating keeps ready low while reset is held
  always_comb begin
    state_nxt  = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n) begin
          grant0 = req0_valid && (!req1_valid || last_grant);
          grant1 = req1_valid && !grant0;
          if (grant0 || grant1) begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    req0_ready = grant0;
    req1_ready = grant1;
  end

  // Shared ALU on latched operands; SUB is two's-complement a + ~b + 1
  always_comb begin
    alu_y = '0;
    unique case (op_code)
      2'b00:   alu_y = op_a & op_b;
      2'b01:   alu_y = op_a | op_b;
      2'b10:   alu_y = op_a + ~op_b + WIDTH'(1);
      default: alu_y = op_a + op_b;
    endcase
  end

  // Operand latch, arbitration history and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_code    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
    end else begin
      if (grant0) begin
        op_code    <= req0_code;
        op_a       <= req0_a;
        op_b       <= req0_b;
        op_id      <= 1'b0;
        last_grant <= 1'b0;
      end else if (grant1) begin
        op_code    <= req1_code;
        op_a       <= req1_a;
        op_b       <= req1_b;
        op_id      <= 1'b1;
        last_grant <= 1'b1;
      end
      if (state == EXEC) begin
        res_data  <= alu_y;
        res_id    <= op_id;
        res_valid <= 1'b1;
      end else if ((state == RESP) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating accepted-request counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && (grant_cnt0 != CNT_MAX)) begin
        grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      end
      if (grant1 && (grant_cnt1 != CNT_MAX)) begin
        grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: per-channel drivers, reference model and monitor.
module tb_alu_share_arb;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_code, req1_code;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       res_valid, res_ready, res_id;
  logic [3:0] res_data;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  alu_share_arb #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_code(req0_code),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_code(req1_code),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  typedef struct { logic [1:0] code; logic [3:0] a; logic [3:0] b; } op_t;
  typedef struct { logic [3:0] d; logic id; } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t exp_q[$];
  int   gq[$];
  int   errors = 0;
  int   checks = 0;
  bit   acc0 = 0, acc1 = 0;
  bit   rr_rand = 0;

  // Model state: one op in flight at a time, result due two cycles after grant
  int   cyc = 0;
  int   acc_c = 0;
  int   free_cyc = 0;
  bit   inflight = 0;
  bit   last = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] alu_ref(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
    int unsigned av, bv, r;
    av = a;
    bv = b;
    case (c)
      2'd0:    r = av & bv;
      2'd1:    r = av | bv;
      2'd2:    r = (av + 16 - bv) % 16;
      default: r = (av + bv) % 16;
    endcase
    return 4'(r);
  endfunction

  function automatic op_t mk(input int c, input int a, input int b);
    op_t o;
    o.code = 2'(c);
    o.a    = 4'(a);
    o.b    = 4'(b);
    return o;
  endfunction

  always @(negedge clk) begin
    acc0 = req0_ready;
    acc1 = req1_ready;
  end

  // Requester 0: holds valid/payload until accepted, scrambles operands when idle
  initial begin
    req0_valid = 0; req0_code = 0; req0_a = 0; req0_b = 0;
    forever begin
      @(posedge clk); #1;
      if (acc0 && req0_valid && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        req0_valid = 1; req0_code = q0[0].code; req0_a = q0[0].a; req0_b = q0[0].b;
      end else begin
        req0_valid = 0; req0_code = 2'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
      end
    end
  end

  // Requester 1
  initial begin
    req1_valid = 0; req1_code = 0; req1_a = 0; req1_b = 0;
    forever begin
      @(posedge clk); #1;
      if (acc1 && req1_valid && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        req1_valid = 1; req1_code = q1[0].code; req1_a = q1[0].a; req1_b = q1[0].b;
      end else begin
        req1_valid = 0; req1_code = 2'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor + reference model, evaluated mid-cycle while inputs are stable
  always @(negedge clk) begin
    bit exp_rv, g0, g1;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      inflight = 0;
      last     = 1;
      free_cyc = 0;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
    end else begin
      exp_rv = inflight && (cyc >= acc_c + 2);
      chk("res_valid", res_valid, exp_rv);
      if (res_valid && exp_rv && exp_q.size() > 0) begin
        chk("res_data", res_data, exp_q[0].d);
        chk("res_id", res_id, exp_q[0].id);
        if (res_ready) begin
          void'(exp_q.pop_front());
          inflight = 0;
          free_cyc = cyc + 1;
        end
      end
      g0 = 0;
      g1 = 0;
      if (!inflight && cyc >= free_cyc) begin
        if (req0_valid && (!req1_valid || last)) g0 = 1;
        else if (req1_valid) g1 = 1;
      end
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      if (g0) begin
        exp_q.push_back('{d: alu_ref(req0_code, req0_a, req0_b), id: 1'b0});
      end else if (g1) begin
        exp_q.push_back('{d: alu_ref(req1_code, req1_a, req1_b), id: 1'b1});
      end
      if (g0 || g1) begin
        inflight = 1;
        acc_c    = cyc;
        last     = g1;
        gq.push_back(g1 ? 1 : 0);
      end
    end
  end

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || inflight || req0_valid || req1_valid) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, (n >= maxc) ? 1 : 0, 0);
  endtask

  initial begin
    int n;
    rst_n = 0;
    res_ready = 1;
    repeat (1) @(posedge clk);
    #1;
    chk("reset_res_data", res_data, 0);
    chk("reset_res_id", res_id, 0);
    chk("reset_res_valid", res_valid, 0);
    @(posedge clk); #1 rst_n = 1;

    // Single op on channel 0: 9 + 8 wraps to 1
    q0.push_back(mk(3, 9, 8));
    wait_drain(20, "drain_single");

    // All ops on channel 1 plus a wrapping subtract
    for (int c = 0; c < 4; c++) q1.push_back(mk(c, 12, 10));
    q1.push_back(mk(2, 3, 5));
    wait_drain(60, "drain_ops");

    // Contention from reset: channel 0 must win first, then alternate
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(i, 1 + i, 7));
      q1.push_back(mk(3 - i, 14 - i, 2));
    end
    do_reset();
    gq.delete();
    wait_drain(60, "drain_contend");
    for (int i = 0; i < 4; i++) chk("contend_order", gq[i], i % 2);

    // Back-pressure: result held five cycles, competing request waits
    res_ready = 0;
    q0.push_back(mk(1, 5, 3));
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid_timeout", (n >= 20) ? 1 : 0, 0);
    q1.push_back(mk(0, 15, 6));
    repeat (5) @(negedge clk);
    @(posedge clk); #1 res_ready = 1;
    wait_drain(40, "drain_bp");

    // Reset during EXEC: nothing emerges afterwards, channel 0 wins next
    q0.push_back(mk(3, 7, 7));
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
    chk("exec_accept_timeout", (n >= 20) ? 1 : 0, 0);
    @(posedge clk); #1;
    rst_n = 0;
    #1 chk("exec_rst_valid", res_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    gq.delete();
    q1.push_back(mk(2, 9, 4));
    q0.push_back(mk(0, 9, 4));
    wait_drain(40, "drain_after_rst");
    chk("post_rst_first_grant", gq[0], 0);

    // Reset while holding a result: res_valid drops asynchronously
    res_ready = 0;
    q1.push_back(mk(1, 2, 8));
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("resp_valid_timeout", (n >= 20) ? 1 : 0, 0);
    #2 rst_n = 0;
    #1 chk("resp_rst_async_valid", res_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    res_ready = 1;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure
    rr_rand = 1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0)
        q0.push_back(mk($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15)));
      if (q1.size() < 2 && $urandom_range(0, 2) == 0)
        q1.push_back(mk($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15)));
      @(posedge clk); #1;
    end
    rr_rand = 0;
    @(posedge clk); #1 res_ready = 1;
    wait_drain(100, "drain_random");

`ifdef ALU_ARB_STATS_EN
    // Counter saturation after 300 channel-0 grants
    do_reset();
    for (int i = 0; i < 300; i++) q0.push_back(mk(i % 4, i % 16, (i / 16) % 16));
    wait_drain(1200, "drain_stats");
    chk("grant_cnt0_sat", grant_cnt0, 255);
    chk("grant_cnt1_zero", grant_cnt1, 0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
